// File: rtl/task4_pkg.sv
// Shared definitions for the ARC4 key-search block: FSM encodings,
// seven-segment codes and the printable-byte window.
package task4_pkg;

    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] INIT        = 4'd1;
    localparam logic [3:0] KSA_RD_I    = 4'd2;
    localparam logic [3:0] KSA_RD_J    = 4'd3;
    localparam logic [3:0] KSA_WR      = 4'd4;
    localparam logic [3:0] PRGA_RD_I   = 4'd5;
    localparam logic [3:0] PRGA_RD_J   = 4'd6;
    localparam logic [3:0] PRGA_WR     = 4'd7;
    localparam logic [3:0] PRGA_RD_PAD = 4'd8;
    localparam logic [3:0] CHECK       = 4'd9;
    localparam logic [3:0] NEXT_KEY    = 4'd10;
    localparam logic [3:0] FOUND       = 4'd11;
    localparam logic [3:0] FAIL        = 4'd12;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low segments, bit0 = a; entry n is hex digit n.
    localparam logic [15:0][6:0] SEG_DIGIT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [7:0] PT_MIN = 8'h20;
    localparam logic [7:0] PT_MAX = 8'h7E;

    function automatic logic printable(input logic [7:0] b);
        return (b >= PT_MIN) && (b <= PT_MAX);
    endfunction

endpackage

// File: rtl/task4_ct.sv
// Ciphertext store: 256x8 with one-cycle synchronous read.
// Contents are preloaded externally and never written by the search logic.
module task4_ct (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] rdata
);

    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        rdata <= mem[addr];
    end

endmodule

// File: rtl/task4_seg7.sv
// Hex nibble to active-low seven-segment code.
module seg7
    import task4_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = SEG_DIGIT[val];

endmodule

// File: rtl/task4.sv
// Brute-force ARC4 key search: tries keys 0..MAX_KEY until every decrypted
// byte is printable, then shows the key on the hex displays.
module task4
    import task4_pkg::*;
#(
    parameter logic [23:0] MAX_KEY = 24'hFFFFFF
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    logic        rst;
    logic        unused_inputs;
    logic [3:0]  state;
    logic [23:0] key;
    logic [7:0]  i, j, k, len, si, t;
    logic [1:0]  m;
    logic        found, done;

    logic [7:0]  s_mem [256];
    logic [7:0]  s_rdata, s_raddr;
    logic        s_we_a, s_we_b;
    logic [7:0]  s_wd_a;
    logic [7:0]  ct_rdata;
    logic [7:0]  key_byte, ksa_j, prga_j, pt;
    logic [5:0][6:0] digit, hex;

    assign rst           = ~KEY[3];
    assign unused_inputs = ^{SW, KEY[2:0]};

    // ct address is the byte index k; k stays 0 through Init so ct[0] is ready.
    task4_ct ct (.clk(CLOCK_50), .addr(k), .rdata(ct_rdata));

    always_comb begin
        case (m)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    end

    assign ksa_j  = j + s_rdata + key_byte;
    assign prga_j = j + s_rdata;
    assign pt     = ct_rdata ^ s_rdata;

    always_comb begin
        case (state)
            KSA_RD_J:    s_raddr = ksa_j;
            PRGA_RD_I:   s_raddr = i + 8'd1;
            PRGA_RD_J:   s_raddr = prga_j;
            PRGA_RD_PAD: s_raddr = t;
            default:     s_raddr = i;
        endcase
    end

    // Swap writes S[i] <= S[j] (just read) and S[j] <= S[i] (held in si).
    assign s_we_a = (state == INIT) || (state == KSA_WR) || (state == PRGA_WR);
    assign s_we_b = (state == KSA_WR) || (state == PRGA_WR);
    assign s_wd_a = (state == INIT) ? i : s_rdata;

    always_ff @(posedge CLOCK_50) begin
        if (s_we_a) s_mem[i] <= s_wd_a;
        if (s_we_b) s_mem[j] <= si;
        s_rdata <= s_mem[s_raddr];
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state <= IDLE;
            key   <= '0;
            found <= 1'b0;
            done  <= 1'b0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i     <= '0;
                    k     <= '0;
                    state <= INIT;
                end
                INIT: begin
                    if (i == 8'hFF) begin
                        i     <= '0;
                        j     <= '0;
                        m     <= '0;
                        len   <= ct_rdata;
                        state <= KSA_RD_I;
                    end else begin
                        i <= i + 8'd1;
                    end
                end
                KSA_RD_I: state <= KSA_RD_J;
                KSA_RD_J: begin
                    si    <= s_rdata;
                    j     <= ksa_j;
                    state <= KSA_WR;
                end
                KSA_WR: begin
                    if (i == 8'hFF) begin
                        i <= '0;
                        j <= '0;
                        k <= 8'd1;
                        if (len == 8'd0) begin
                            found <= 1'b1;
                            done  <= 1'b1;
                            state <= FOUND;
                        end else begin
                            state <= PRGA_RD_I;
                        end
                    end else begin
                        i     <= i + 8'd1;
                        m     <= (m == 2'd2) ? 2'd0 : m + 2'd1;
                        state <= KSA_RD_I;
                    end
                end
                PRGA_RD_I: begin
                    i     <= i + 8'd1;
                    state <= PRGA_RD_J;
                end
                PRGA_RD_J: begin
                    si    <= s_rdata;
                    j     <= prga_j;
                    state <= PRGA_WR;
                end
                PRGA_WR: begin
                    t     <= si + s_rdata;
                    state <= PRGA_RD_PAD;
                end
                PRGA_RD_PAD: state <= CHECK;
                CHECK: begin
                    if (!printable(pt)) begin
                        state <= NEXT_KEY;
                    end else if (k == len) begin
                        found <= 1'b1;
                        done  <= 1'b1;
                        state <= FOUND;
                    end else begin
                        k     <= k + 8'd1;
                        state <= PRGA_RD_I;
                    end
                end
                NEXT_KEY: begin
                    if (key == MAX_KEY) begin
                        done  <= 1'b1;
                        state <= FAIL;
                    end else begin
                        key   <= key + 24'd1;
                        i     <= '0;
                        k     <= '0;
                        state <= INIT;
                    end
                end
                FOUND:   state <= FOUND;
                FAIL:    state <= FAIL;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_seg
        seg7 u_seg (.val(key[4*g +: 4]), .seg(digit[g]));
    end

    always_comb begin
        hex = {6{SEG_BLANK}};
        if (state == FOUND)     hex = digit;
        else if (state == FAIL) hex = {6{SEG_DASH}};
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = hex[5];
    assign LEDR = {8'd0, done, found};

endmodule

// File: tb/tb_task4.sv
// Randomized self-checking bench for task4 against a plain ARC4 search model.
module tb_task4;

    logic       clk = 1'b0;
    logic [3:0] key_a = 4'hF;
    logic [3:0] key_f = 4'hF;
    logic [9:0] sw = '0;
    logic [6:0] a0, a1, a2, a3, a4, a5;
    logic [6:0] f0, f1, f2, f3, f4, f5;
    logic [9:0] ledr_a, ledr_f;

    always #10 clk = ~clk;

    task4 dut (
        .CLOCK_50(clk), .KEY(key_a), .SW(sw),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5),
        .LEDR(ledr_a)
    );

    task4 #(.MAX_KEY(24'd15)) dut_f (
        .CLOCK_50(clk), .KEY(key_f), .SW(sw),
        .HEX0(f0), .HEX1(f1), .HEX2(f2), .HEX3(f3), .HEX4(f4), .HEX5(f5),
        .LEDR(ledr_f)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ct_img [256];
    int pt_img [256];
    int ks     [256];

    logic [41:0] blank_all, dash_all;
    logic [41:0] hex_a, hex_f;
    assign hex_a = {a5, a4, a3, a2, a1, a0};
    assign hex_f = {f5, f4, f3, f2, f1, f0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hexdig(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [41:0] hex_of(input logic [23:0] kk);
        return {hexdig(kk[23:20]), hexdig(kk[19:16]), hexdig(kk[15:12]),
                hexdig(kk[11:8]), hexdig(kk[7:4]), hexdig(kk[3:0])};
    endfunction

    // Textbook ARC4: first n keystream bytes for key kk into ks[].
    task automatic gen_ks(input logic [23:0] kk, input int n);
        int s [256];
        int kb [3];
        int x, y, tmp;
        kb[0] = int'(kk[23:16]);
        kb[1] = int'(kk[15:8]);
        kb[2] = int'(kk[7:0]);
        for (int a = 0; a < 256; a++) s[a] = a;
        y = 0;
        for (int a = 0; a < 256; a++) begin
            y = (y + s[a] + kb[a % 3]) % 256;
            tmp = s[a]; s[a] = s[y]; s[y] = tmp;
        end
        x = 0; y = 0;
        for (int b = 0; b < n; b++) begin
            x = (x + 1) % 256;
            y = (y + s[x]) % 256;
            tmp = s[x]; s[x] = s[y]; s[y] = tmp;
            ks[b] = s[(s[x] + s[y]) % 256];
        end
    endtask

    task automatic encrypt(input logic [23:0] kk, input int n);
        ct_img[0] = n;
        gen_ks(kk, n);
        for (int b = 0; b < n; b++) ct_img[b + 1] = pt_img[b] ^ ks[b];
        for (int a = n + 1; a < 256; a++) ct_img[a] = int'($urandom_range(0, 255));
    endtask

    task automatic model_accept(input logic [23:0] kk, output bit ok);
        int p;
        gen_ks(kk, ct_img[0]);
        ok = 1'b1;
        for (int b = 0; b < ct_img[0]; b++) begin
            p = ct_img[b + 1] ^ ks[b];
            if (p < 32 || p > 126) ok = 1'b0;
        end
    endtask

    task automatic model_search(input logic [23:0] maxk, output bit fnd, output logic [23:0] kout);
        bit ok;
        fnd  = 1'b0;
        kout = maxk;
        for (int c = 0; c <= int'(maxk) && c < 4096 && !fnd; c++) begin
            model_accept(24'(c), ok);
            if (ok) begin
                fnd  = 1'b1;
                kout = 24'(c);
            end
        end
    endtask

    task automatic load_a();
        for (int a = 0; a < 256; a++) dut.ct.mem[a] = ct_img[a][7:0];
    endtask

    task automatic load_f();
        for (int a = 0; a < 256; a++) dut_f.ct.mem[a] = ct_img[a][7:0];
    endtask

    task automatic wait_a(input string tag, input int budget);
        int cyc = 0;
        while (ledr_a[1] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 64'(ledr_a[1]), 64'd1);
    endtask

    task automatic result_a(input string tag, input bit fnd, input logic [23:0] kk);
        check({tag, "_key"}, 64'(dut.key), 64'(kk));
        check({tag, "_ledr"}, 64'(ledr_a), {54'd0, 8'd0, 1'b1, fnd});
        check({tag, "_hex"}, 64'(hex_a), 64'(fnd ? hex_of(kk) : dash_all));
    endtask

    task automatic run_a(input string tag, input bit fnd, input logic [23:0] kk);
        @(negedge clk) key_a[3] = 1'b0;
        @(negedge clk) key_a[3] = 1'b1;
        wait_a({tag, "_done"}, (int'(kk) + 1) * (1600 + 8 * ct_img[0]) + 10);
        result_a(tag, fnd, kk);
    endtask

    initial begin
        bit          fa, ff;
        logic [23:0] ka, kf;
        string       msg;
        logic [7:0]  tgt [4];
        int          cyc;

        blank_all = {6{7'b1111111}};
        dash_all  = {6{7'b0111111}};

        // "Hi" under key 0x18 on the wide DUT; long message under key 0x40
        // on the MAX_KEY=15 DUT so that search exhausts.
        pt_img[0] = 8'h48;
        pt_img[1] = 8'h69;
        encrypt(24'h000018, 2);
        model_search(24'hFFFFFF, fa, ka);
        load_a();
        for (int b = 0; b < 16; b++) pt_img[b] = int'($urandom_range(32, 126));
        encrypt(24'h000040, 16);
        model_search(24'd15, ff, kf);
        load_f();

        @(negedge clk);
        key_a[3] = 1'b0;
        key_f[3] = 1'b0;
        @(negedge clk);
        check("rst_key", 64'(dut.key), 64'd0);
        check("rst_ledr", 64'(ledr_a), 64'd0);
        check("rst_hex", 64'(hex_a), 64'(blank_all));
        check("rst_ledr_f", 64'(ledr_f), 64'd0);
        key_a[3] = 1'b1;
        key_f[3] = 1'b1;

        repeat (6000) @(negedge clk);
        key_a[3] = 1'b0;
        @(negedge clk);
        check("mid_rst_key", 64'(dut.key), 64'd0);
        check("mid_rst_hex", 64'(hex_a), 64'(blank_all));
        check("mid_rst_ledr", 64'(ledr_a), 64'd0);
        key_a[3] = 1'b1;
        wait_a("hi_done", 30000);
        result_a("hi", fa, ka);

        cyc = 0;
        while (ledr_f[1] !== 1'b1 && cyc < 16 * 1728 + 50) begin
            @(negedge clk);
            cyc++;
        end
        check("maxk_key", 64'(dut_f.key), 64'(kf));
        check("maxk_ledr", 64'(ledr_f), {54'd0, 8'd0, 1'b1, ff});
        check("maxk_hex", 64'(hex_f), 64'(ff ? hex_of(kf) : dash_all));

        // Reload with a new message under key 0x0F.
        msg = "Hello, FPGA!";
        for (int b = 0; b < msg.len(); b++) pt_img[b] = int'(msg[b]);
        encrypt(24'h00000F, msg.len());
        model_search(24'hFFFFFF, fa, ka);
        load_a();
        run_a("key0f", fa, ka);
        check("key0f_hex0", 64'(a0), 64'(hexdig(ka[3:0])));

        // Empty message: first candidate accepted right after KSA.
        encrypt(24'h000000, 0);
        model_search(24'hFFFFFF, fa, ka);
        load_a();
        run_a("empty", fa, ka);

        // Single-byte messages whose key-0 plaintext sits on each window edge.
        tgt[0] = 8'h1F; tgt[1] = 8'h20; tgt[2] = 8'h7E; tgt[3] = 8'h7F;
        for (int e = 0; e < 4; e++) begin
            ct_img[0] = 1;
            gen_ks(24'h000000, 1);
            ct_img[1] = ks[0] ^ int'(tgt[e]);
            model_search(24'hFFFFFF, fa, ka);
            load_a();
            run_a($sformatf("edge_%0h", tgt[e]), fa, ka);
        end

        for (int r = 0; r < 2; r++) begin
            int n;
            logic [23:0] kr;
            n  = int'($urandom_range(1, 6));
            kr = 24'($urandom_range(0, 3));
            for (int b = 0; b < n; b++) pt_img[b] = int'($urandom_range(32, 126));
            encrypt(kr, n);
            model_search(24'hFFFFFF, fa, ka);
            load_a();
            run_a($sformatf("rand%0d", r), fa, ka);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
